// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports,
// link-register port and busy scoreboard. CLK/RST stay plain module ports.
`timescale 1ns/1ps

interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]             wen;
    logic [NWR-1:0][AW-1:0]     wsel;
    logic [NWR-1:0][DATA_W-1:0] wdat;
    logic [NRD-1:0][AW-1:0]     rsel;
    logic [NRD-1:0][DATA_W-1:0] rdat;
    logic [NRD-1:0]             rrdy;
    logic                       link_en;
    logic [DATA_W-1:0]          link_dat;
    logic                       hold;
    logic                       claim_en;
    logic [AW-1:0]              claim_sel;
    logic [NREGS-1:0]           busy;

    // Issue/writeback side driving the register file
    modport master (
        output wen, wsel, wdat, rsel, link_en, link_dat, hold, claim_en, claim_sel,
        input  rdat, rrdy, busy
    );

    // The register file itself
    modport slave (
        input  wen, wsel, wdat, rsel, link_en, link_dat, hold, claim_en, claim_sel,
        output rdat, rrdy, busy
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port integer register file with link-register write port, optional
// same-cycle write-to-read bypass and a per-register busy scoreboard.
// Register 0 reads as zero and ignores writes, link writes and claims.
`timescale 1ns/1ps

module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int LINK_REG = NREGS - 1
) (
    input logic CLK,
    input logic RST,
    register_file_mp_if.slave bus
);
    localparam int          AW       = $clog2(NREGS);
    localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

    // Architectural state
    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0]             busy_q;

    // Per-register outcome of this cycle's write arbitration
    logic [NREGS-1:0]             wr_hit;
    logic [NREGS-1:0][DATA_W-1:0] wr_val;
    logic [NREGS-1:0]             claim_vec;
    logic [NREGS-1:0]             busy_nxt;
    logic                         link_ok;
    logic                         claim_ok;

    // Arbitrate writes per target: link first, then wen ports in ascending
    // order so the highest-indexed enabled port overwrites everything below.
    always_comb begin
        wr_hit  = '0;
        wr_val  = '0;
        link_ok = bus.link_en & ~bus.hold;
        if (link_ok && (LINK_IDX != '0)) begin
            wr_hit[LINK_IDX] = 1'b1;
            wr_val[LINK_IDX] = bus.link_dat;
        end
        for (int p = 0; p < NWR; p++) begin
            if (bus.wen[p] && (bus.wsel[p] != '0)) begin
                wr_hit[bus.wsel[p]] = 1'b1;
                wr_val[bus.wsel[p]] = bus.wdat[p];
            end
        end
    end

    // Scoreboard next state: a landed write clears, a same-cycle claim re-sets
    // (the newly issued producer owns the register).
    always_comb begin
        claim_vec = '0;
        claim_ok  = bus.claim_en & ~bus.hold & (bus.claim_sel != '0);
        if (claim_ok) begin
            claim_vec[bus.claim_sel] = 1'b1;
        end
        busy_nxt = (busy_q & ~wr_hit) | claim_vec;
    end

    // Register and scoreboard update; reset overrides every same-cycle write
    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
            busy_q <= busy_nxt;
        end
    end

    // Combinational read ports with optional forwarding of the winning write
    always_comb begin
        bus.rdat = '0;
        bus.rrdy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rsel[i] == '0) begin
                bus.rdat[i] = '0;
                bus.rrdy[i] = 1'b1;
            end else if ((BYPASS != 0) && wr_hit[bus.rsel[i]]) begin
                bus.rdat[i] = wr_val[bus.rsel[i]];
                bus.rrdy[i] = 1'b1;
            end else begin
                bus.rdat[i] = regs_q[bus.rsel[i]];
                bus.rrdy[i] = ~busy_q[bus.rsel[i]];
            end
        end
    end

    assign bus.busy = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two instances (A: NWR=2, BYPASS=1, LINK_REG=9;
// B: NWR=1, BYPASS=0, LINK_REG=31) share one stimulus stream and are
// compared every cycle against an array/priority-search reference model.
`timescale 1ns/1ps

module tb_register_file_mp;
    logic CLK = 1'b0;
    logic s_rst;
    always #5 CLK = ~CLK;

    register_file_mp_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
    register_file_mp_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(1)) ifb ();

    register_file_mp #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .LINK_REG(9))
        dut_a (.CLK(CLK), .RST(s_rst), .bus(ifa));
    register_file_mp #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .LINK_REG(31))
        dut_b (.CLK(CLK), .RST(s_rst), .bus(ifb));

    // Shared stimulus (instance B sees write port 0 only)
    logic [1:0]  s_wen;
    logic [4:0]  s_wsel [2];
    logic [31:0] s_wdat [2];
    logic [4:0]  s_rsel [2];
    logic        s_link_en, s_hold, s_claim_en;
    logic [31:0] s_link_dat;
    logic [4:0]  s_claim_sel;

    // Reference model state and per-instance configuration
    logic [31:0] mem [2][32];
    bit          bz  [2][32];
    int          NWRC  [2] = '{2, 1};
    int          BYPC  [2] = '{1, 0};
    int          LINKC [2] = '{9, 31};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Which write lands on register r this cycle: search ports from the
    // highest index down, link only if no port claimed the register.
    task automatic winner(input int d, input int r, output bit hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (r == 0) return;
        for (int p = NWRC[d] - 1; p >= 0; p--) begin
            if (s_wen[p] && (int'(s_wsel[p]) == r)) begin
                hit = 1'b1;
                val = s_wdat[p];
                return;
            end
        end
        if (s_link_en && !s_hold && LINKC[d] == r) begin
            hit = 1'b1;
            val = s_link_dat;
        end
    endtask

    task automatic drive();
        ifa.wen = s_wen;
        ifb.wen = s_wen[0];
        for (int p = 0; p < 2; p++) begin
            ifa.wsel[p] = s_wsel[p];
            ifa.wdat[p] = s_wdat[p];
            ifa.rsel[p] = s_rsel[p];
            ifb.rsel[p] = s_rsel[p];
        end
        ifb.wsel[0] = s_wsel[0];
        ifb.wdat[0] = s_wdat[0];
        ifa.link_en = s_link_en;   ifb.link_en = s_link_en;
        ifa.link_dat = s_link_dat; ifb.link_dat = s_link_dat;
        ifa.hold = s_hold;         ifb.hold = s_hold;
        ifa.claim_en = s_claim_en; ifb.claim_en = s_claim_en;
        ifa.claim_sel = s_claim_sel; ifb.claim_sel = s_claim_sel;
    endtask

    task automatic idle();
        s_rst = 1'b0; s_wen = '0;
        s_wsel[0] = '0; s_wsel[1] = '0; s_wdat[0] = '0; s_wdat[1] = '0;
        s_link_en = 1'b0; s_link_dat = '0; s_hold = 1'b0;
        s_claim_en = 1'b0; s_claim_sel = '0;
    endtask

    task automatic check_outputs();
        bit          hit;
        logic [31:0] val, exp_d, obs_d;
        logic        exp_r, obs_r;
        logic [31:0] exp_b;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                winner(d, int'(s_rsel[i]), hit, val);
                if (s_rsel[i] == 0) begin
                    exp_d = '0; exp_r = 1'b1;
                end else if (BYPC[d] == 1 && hit) begin
                    exp_d = val; exp_r = 1'b1;
                end else begin
                    exp_d = mem[d][s_rsel[i]]; exp_r = !bz[d][s_rsel[i]];
                end
                obs_d = (d == 0) ? ifa.rdat[i] : ifb.rdat[i];
                obs_r = (d == 0) ? ifa.rrdy[i] : ifb.rrdy[i];
                check_val($sformatf("rdat d%0d p%0d", d, i), obs_d, exp_d);
                check_val($sformatf("rrdy d%0d p%0d", d, i), 32'(obs_r), 32'(exp_r));
            end
            exp_b = '0;
            for (int r = 0; r < 32; r++) exp_b[r] = bz[d][r];
            check_val($sformatf("busy d%0d", d), (d == 0) ? ifa.busy : ifb.busy, exp_b);
        end
    endtask

    task automatic model_update();
        bit          hit;
        logic [31:0] val;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) begin
                if (s_rst) begin
                    mem[d][r] = '0;
                    bz[d][r]  = 1'b0;
                end else if (r != 0) begin
                    winner(d, r, hit, val);
                    if (hit) mem[d][r] = val;
                    if (s_claim_en && !s_hold && int'(s_claim_sel) == r) bz[d][r] = 1'b1;
                    else if (hit) bz[d][r] = 1'b0;
                end
            end
        end
    endtask

    // Inputs are applied after the falling edge; check, then clock once.
    task automatic step();
        drive();
        #1;
        check_outputs();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 9));
    endfunction

    initial begin
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin mem[d][r] = 'x; bz[d][r] = 1'b0; end
        idle();
        s_rsel[0] = 5'd0; s_rsel[1] = 5'd0;
        drive();
        @(negedge CLK);
        // Initial reset; model treats pre-reset state as unknown so skip checks
        s_rst = 1'b1; drive();
        @(posedge CLK); model_update(); @(negedge CLK);
        @(posedge CLK); model_update(); @(negedge CLK);

        // Reset clears written data
        idle(); s_wen = 2'b01; s_wsel[0] = 5'd5; s_wdat[0] = 32'hDEADBEEF; s_rsel[0] = 5'd5;
        step();
        idle(); s_rst = 1'b1; step(); step();
        idle(); drive(); #1;
        check_val("reset rdat a", ifa.rdat[0], 32'h0);
        check_val("reset rdat b", ifb.rdat[0], 32'h0);
        check_val("reset busy", ifa.busy | ifb.busy, 32'h0);
        check_val("reset rrdy", {30'h0, ifa.rrdy}, 32'h3);
        step();

        // r0 protection
        s_wen = 2'b01; s_wsel[0] = 5'd0; s_wdat[0] = 32'h12345678;
        s_claim_en = 1'b1; s_claim_sel = 5'd0; s_rsel[0] = 5'd0;
        step();
        idle(); drive(); #1;
        check_val("r0 rdat", ifa.rdat[0] | ifb.rdat[0], 32'h0);
        check_val("r0 busy", 32'({ifa.busy[0], ifb.busy[0]}), 32'h0);
        check_val("r0 rrdy", 32'(ifa.rrdy[0] & ifb.rrdy[0]), 32'h1);
        step();

        // Bypass vs. stored-only read
        s_wen = 2'b01; s_wsel[0] = 5'd7; s_wdat[0] = 32'hA5A5A5A5; s_rsel[0] = 5'd7;
        drive(); #1;
        check_val("bypass a", ifa.rdat[0], 32'hA5A5A5A5);
        check_val("nobypass old b", ifb.rdat[0], 32'h0);
        step();
        idle(); drive(); #1;
        check_val("nobypass next b", ifb.rdat[0], 32'hA5A5A5A5);
        step();

        // Port conflict on r9 (A's link register)
        s_wen = 2'b11; s_wsel[0] = 5'd9; s_wdat[0] = 32'h1; s_wsel[1] = 5'd9; s_wdat[1] = 32'h2;
        s_link_en = 1'b1; s_link_dat = 32'h3; s_rsel[0] = 5'd9;
        drive(); #1;
        check_val("conflict bypass a", ifa.rdat[0], 32'h2);
        step();
        idle(); drive(); #1;
        check_val("conflict stored a", ifa.rdat[0], 32'h2);
        step();

        // Link port on B (LINK_REG=31), which took 0x3 in the previous block
        s_rsel[0] = 5'd31;
        s_link_en = 1'b1; s_link_dat = 32'h00400010; s_hold = 1'b1;
        step();
        idle(); drive(); #1;
        check_val("link hold b", ifb.rdat[0], 32'h3);
        s_link_en = 1'b1; s_link_dat = 32'h00400010;
        step();
        idle(); drive(); #1;
        check_val("link b", ifb.rdat[0], 32'h00400010);
        s_link_en = 1'b1; s_link_dat = 32'h00400020; s_wen = 2'b01; s_wsel[0] = 5'd31; s_wdat[0] = 32'h55;
        step();
        idle(); drive(); #1;
        check_val("wen beats link b", ifb.rdat[0], 32'h55);
        step();

        // Scoreboard on r4
        s_claim_en = 1'b1; s_claim_sel = 5'd4; s_rsel[0] = 5'd4;
        step();
        idle(); drive(); #1;
        check_val("claim busy a", 32'(ifa.busy[4]), 32'h1);
        check_val("claim rrdy b", 32'(ifb.rrdy[0]), 32'h0);
        step();
        s_wen = 2'b01; s_wsel[0] = 5'd4; s_wdat[0] = 32'h44; s_claim_en = 1'b1; s_claim_sel = 5'd4;
        step();
        idle(); drive(); #1;
        check_val("reclaim busy b", 32'(ifb.busy[4]), 32'h1);
        check_val("reclaim data b", ifb.rdat[0], 32'h44);
        s_wen = 2'b01; s_wsel[0] = 5'd4; s_wdat[0] = 32'h45;
        drive(); #1;
        check_val("bypass rrdy a", 32'(ifa.rrdy[0]), 32'h1);
        check_val("no bypass rrdy b", 32'(ifb.rrdy[0]), 32'h0);
        step();
        idle(); drive(); #1;
        check_val("clear busy", 32'({ifa.busy[4], ifb.busy[4]}), 32'h0);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            s_rst = ($urandom_range(0, 99) == 0);
            if (!s_rst) begin
                s_wen       = 2'($urandom_range(0, 3));
                s_wsel[0]   = rand_addr(); s_wsel[1] = rand_addr();
                s_wdat[0]   = $urandom;    s_wdat[1] = $urandom;
                s_link_en   = ($urandom_range(0, 3) == 0);
                s_link_dat  = $urandom;
                s_hold      = ($urandom_range(0, 3) == 0);
                s_claim_en  = ($urandom_range(0, 2) == 0);
                s_claim_sel = rand_addr();
            end
            s_rsel[0] = rand_addr(); s_rsel[1] = rand_addr();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
